// File: rtl/riscv_ctrl_pkg.sv
// Shared RISC-V control definitions: ALU op encoding, opcode/func7 constants,
// multicycle FSM states and the base instruction field layout.
package riscv_ctrl_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned F7_W     = 7;
  localparam int unsigned REG_W    = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001
  } alu_op_e;

  localparam logic [OPC_W-1:0] OPC_R    = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I    = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD = 7'b0000011;

  localparam logic [F7_W-1:0] F7_ZERO = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } mc_state_e;

  // R-type view of a 32-bit instruction; I-type shares opcode/rd/func3/rs1 and
  // the shift func7 sits where R-type func7 does.
  typedef struct packed {
    logic [F7_W-1:0]  func7;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rs1;
    logic [F3_W-1:0]  func3;
    logic [REG_W-1:0] rd;
    logic [OPC_W-1:0] opcode;
  } rv_instr_t;

  function automatic logic is_legal_opcode(input logic [OPC_W-1:0] opc);
    return (opc == OPC_R) || (opc == OPC_I) || (opc == OPC_LOAD);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_op_decoder.sv
// Combinational IR -> ALU operation decode, shared with the single-cycle core.
module alu_op_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output alu_op_e     alu_op_o
);

  rv_instr_t ir;
  logic      is_r;

  assign ir   = rv_instr_t'(instr_i);
  assign is_r = (ir.opcode == OPC_R);

  always_comb begin
    alu_op_o = ALU_ADD;
    if ((ir.opcode == OPC_R) || (ir.opcode == OPC_I)) begin
      case (ir.func3)
        3'b000: alu_op_o = (is_r && (ir.func7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
        3'b001: alu_op_o = ALU_SLL;
        3'b010: alu_op_o = ALU_SLT;
        3'b011: alu_op_o = ALU_SLTU;
        3'b100: alu_op_o = ALU_XOR;
        // R-type defaults unknown func7 to srl, I-type defaults it to sra
        3'b101: begin
          if (is_r) alu_op_o = (ir.func7 == F7_ALT)  ? ALU_SRA : ALU_SRL;
          else      alu_op_o = (ir.func7 == F7_ZERO) ? ALU_SRL : ALU_SRA;
        end
        3'b110: alu_op_o = ALU_OR;
        3'b111: alu_op_o = ALU_AND;
        default: alu_op_o = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: fetch into IR, decode, execute, load wait, writeback.
// Optional performance counters enabled by MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned instr_width  = 32,
  parameter int unsigned alu_op_width = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [instr_width-1:0]  imem_rdata,
  input  logic                    imem_ready,
  input  logic                    dmem_ready,
  output logic                    imem_req,
  output logic [instr_width-1:0]  instruction,
  output logic [alu_op_width-1:0] alu_op,
  output logic                    sel_bw_imm_rs2,
  output logic                    dmem_read_en,
  output logic                    wr_back_sel,
  output logic                    regfile_write_enable,
  output logic                    pc_en,
  output logic                    illegal_instr
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]             cycle_cnt,
  output logic [31:0]             instret_cnt
`endif
);

  mc_state_e              state_q, state_d;
  logic [instr_width-1:0] ir_q, ir_d;
  logic [OPC_W-1:0]       opcode;
  logic                   is_load;
  logic                   alu_en;
  alu_op_e                dec_op;

  assign opcode  = ir_q[OPC_W-1:0];
  assign is_load = (opcode == OPC_LOAD);

  alu_op_decoder u_alu_op_decoder (
    .instr_i  (ir_q[31:0]),
    .alu_op_o (dec_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next state and control strobes; everything held low while rst is high
  always_comb begin
    state_d              = state_q;
    ir_d                 = ir_q;
    imem_req             = 1'b0;
    alu_en               = 1'b0;
    dmem_read_en         = 1'b0;
    wr_back_sel          = 1'b0;
    regfile_write_enable = 1'b0;
    pc_en                = 1'b0;
    illegal_instr        = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_d    = imem_rdata;
            state_d = DECODE;
          end
        end
        DECODE: begin
          if (is_legal_opcode(opcode)) begin
            state_d = EXECUTE;
          end else begin
            illegal_instr = 1'b1;
            pc_en         = 1'b1;
            state_d       = FETCH;
          end
        end
        EXECUTE: begin
          alu_en  = 1'b1;
          state_d = is_load ? MEM : WRITEBACK;
        end
        MEM: begin
          alu_en       = 1'b1;
          dmem_read_en = 1'b1;
          if (dmem_ready) state_d = WRITEBACK;
        end
        WRITEBACK: begin
          alu_en               = 1'b1;
          regfile_write_enable = 1'b1;
          pc_en                = 1'b1;
          wr_back_sel          = !is_load;
          state_d              = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign instruction    = rst ? '0 : ir_q;
  assign alu_op         = alu_en ? alu_op_width'(dec_op) : '0;
  assign sel_bw_imm_rs2 = alu_en && (opcode != OPC_R);

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instret_cnt_q;

  // Free-running counters; wrap naturally at 32 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (state_q == WRITEBACK) instret_cnt_q <= instret_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt   = rst ? '0 : cycle_cnt_q;
  assign instret_cnt = rst ? '0 : instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed table, hand sequences,
// and random instructions against a behavioural reference model.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] instruction;
  logic [3:0]  alu_op;
  logic        sel_bw_imm_rs2, dmem_read_en, wr_back_sel;
  logic        regfile_write_enable, pc_en, illegal_instr;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk                  (clk),
    .rst                  (rst),
    .imem_rdata           (imem_rdata),
    .imem_ready           (imem_ready),
    .dmem_ready           (dmem_ready),
    .imem_req             (imem_req),
    .instruction          (instruction),
    .alu_op               (alu_op),
    .sel_bw_imm_rs2       (sel_bw_imm_rs2),
    .dmem_read_en         (dmem_read_en),
    .wr_back_sel          (wr_back_sel),
    .regfile_write_enable (regfile_write_enable),
    .pc_en                (pc_en),
    .illegal_instr        (illegal_instr)
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    ,
    .cycle_cnt            (cycle_cnt),
    .instret_cnt          (instret_cnt)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_ir = '0;
  int unsigned m_cyc = 0;
  int unsigned m_ret = 0;

  always @(posedge clk) begin
    if (rst) m_cyc <= 0;
    else     m_cyc <= m_cyc + 1;
  end

  typedef struct {
    logic [31:0] ins;
    int          fw;
    int          mw;
    logic        legal;
    logic        load;
    logic [3:0]  op;
    logic        sel;
  } vec_t;

  function automatic logic [42:0] pk(input logic req, input logic [31:0] ir,
                                     input logic [3:0] op, input logic sel,
                                     input logic dre, input logic wbs,
                                     input logic we, input logic pce,
                                     input logic ill);
    return {req, ir, op, sel, dre, wbs, we, pce, ill};
  endfunction

  task automatic chk(input string name, input logic [42:0] exp);
    logic [42:0] got;
    got = pk(imem_req, instruction, alu_op, sel_bw_imm_rs2, dmem_read_en,
             wr_back_sel, regfile_write_enable, pc_en, illegal_instr);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic chk_perf(input string name);
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 32'(m_cyc) || instret_cnt !== 32'(m_ret)) begin
      errors++;
      $display("FAIL %s: got cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
               name, cycle_cnt, instret_cnt, m_cyc, m_ret);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  // One clock: drive inputs after the falling edge, settle, then caller checks
  task automatic cyc(input logic ir_rdy, input logic [31:0] rdata, input logic dr);
    @(negedge clk);
    rst        = 1'b0;
    imem_ready = ir_rdy;
    imem_rdata = rdata;
    dmem_ready = dr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    imem_rdata = $urandom;
    #1;
    chk("reset_outputs", '0);
    last_ir = '0;
    m_ret   = 0;
  endtask

  // Reference decode from the instruction-set rules
  function automatic void ref_decode(input logic [31:0] ins, output logic legal,
                                     output logic load, output logic [3:0] op,
                                     output logic sel);
    logic [3:0] base [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    base  = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    legal = (opc == 7'h33) || (opc == 7'h13) || (opc == 7'h03);
    load  = (opc == 7'h03);
    sel   = (opc != 7'h33);
    op    = base[f3];
    if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h20) op = 4'd1;
    if (f3 == 3'd5) begin
      if (opc == 7'h33) op = (f7 == 7'h20) ? 4'd7 : 4'd6;
      else              op = (f7 == 7'h00) ? 4'd6 : 4'd7;
    end
    if (load) op = 4'd0;
  endfunction

  // Full instruction from FETCH to the return to FETCH, every cycle compared
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic legal, input logic load,
                           input logic [3:0] op, input logic sel);
    for (int i = 0; i <= fw; i++) begin
      cyc(i == fw, (i == fw) ? ins : $urandom, 1'($urandom));
      chk("fetch", pk(1'b1, last_ir, 4'd0, 0, 0, 0, 0, 0, 0));
    end
    last_ir = ins;
    cyc(1'($urandom), $urandom, 1'($urandom));
    if (!legal) begin
      chk("decode_illegal", pk(1'b0, ins, 4'd0, 0, 0, 0, 0, 1, 1));
    end else begin
      chk("decode", pk(1'b0, ins, 4'd0, 0, 0, 0, 0, 0, 0));
      cyc(1'($urandom), $urandom, 1'($urandom));
      chk("execute", pk(1'b0, ins, op, sel, 0, 0, 0, 0, 0));
      if (load) begin
        for (int j = 0; j <= mw; j++) begin
          cyc(1'($urandom), $urandom, j == mw);
          chk("mem", pk(1'b0, ins, op, sel, 1, 0, 0, 0, 0));
        end
      end
      cyc(1'($urandom), $urandom, 1'($urandom));
      chk("writeback", pk(1'b0, ins, op, sel, 0, !load, 1, 1, 0));
      m_ret++;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  f7;
    int unsigned k;
    r  = $urandom;
    k  = $urandom_range(0, 2);
    f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : 7'($urandom);
    case ($urandom_range(0, 3))
      0: r = {f7, r[24:7], 7'h33};
      1: r = {f7, r[24:7], 7'h13};
      2: r = {r[31:7], 7'h03};
      default: begin
        if (r[6:0] == 7'h33 || r[6:0] == 7'h13 || r[6:0] == 7'h03) r[6:0] = 7'h63;
      end
    endcase
    return r;
  endfunction

  vec_t tbl [14];

  initial begin
    logic       lg, ld, sl;
    logic [3:0] op;
    logic [31:0] ins;

    tbl[0]  = '{32'h002081B3, 0, 0, 1'b1, 1'b0, 4'h0, 1'b0};  // add
    tbl[1]  = '{32'h402081B3, 0, 0, 1'b1, 1'b0, 4'h1, 1'b0};  // sub
    tbl[2]  = '{32'h4030D293, 0, 0, 1'b1, 1'b0, 4'h7, 1'b1};  // srai
    tbl[3]  = '{32'h0030D293, 0, 0, 1'b1, 1'b0, 4'h6, 1'b1};  // srli
    tbl[4]  = '{32'h0080A283, 0, 3, 1'b1, 1'b1, 4'h0, 1'b1};  // lw, 3 wait
    tbl[5]  = '{32'h002081B3, 5, 0, 1'b1, 1'b0, 4'h0, 1'b0};  // fetch stall
    tbl[6]  = '{32'h00000063, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0};  // beq illegal
    tbl[7]  = '{32'h0020C1B3, 1, 0, 1'b1, 1'b0, 4'h5, 1'b0};  // xor
    tbl[8]  = '{32'h0FF0F193, 0, 0, 1'b1, 1'b0, 4'h9, 1'b1};  // andi
    tbl[9]  = '{32'h0220D1B3, 0, 0, 1'b1, 1'b0, 4'h6, 1'b0};  // R f3=101 odd f7
    tbl[10] = '{32'h4230D293, 0, 0, 1'b1, 1'b0, 4'h7, 1'b1};  // I f3=101 odd f7
    tbl[11] = '{32'h022081B3, 0, 0, 1'b1, 1'b0, 4'h0, 1'b0};  // R f3=000 odd f7
    tbl[12] = '{32'h4000C283, 2, 0, 1'b1, 1'b1, 4'h0, 1'b1};  // lbu, no wait
    tbl[13] = '{32'h0000007F, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0};  // illegal opcode

    do_reset();
    chk_perf("perf_after_reset");

    for (int t = 0; t < 14; t++) begin
      run_instr(tbl[t].ins, tbl[t].fw, tbl[t].mw, tbl[t].legal,
                tbl[t].load, tbl[t].op, tbl[t].sel);
      chk_perf("perf_table");
    end

    // Reset asserted in the second MEM cycle of a load
    cyc(1'b1, 32'h0080A283, 1'b0);
    chk("rm_fetch", pk(1'b1, last_ir, 4'd0, 0, 0, 0, 0, 0, 0));
    last_ir = 32'h0080A283;
    cyc(1'b0, '0, 1'b0);
    chk("rm_decode", pk(1'b0, last_ir, 4'd0, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, '0, 1'b0);
    chk("rm_execute", pk(1'b0, last_ir, 4'd0, 1, 0, 0, 0, 0, 0));
    cyc(1'b0, '0, 1'b0);
    chk("rm_mem1", pk(1'b0, last_ir, 4'd0, 1, 1, 0, 0, 0, 0));
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, $urandom, 1'b1);
      chk("rm_after_release", pk(1'b1, 32'h0, 4'd0, 0, 0, 0, 0, 0, 0));
    end
    chk_perf("perf_after_mem_reset");
    run_instr(32'h402081B3, 0, 0, 1'b1, 1'b0, 4'h1, 1'b0);
    chk_perf("perf_post_reset_instr");

    // Random instructions against the reference model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      ins = rand_instr();
      ref_decode(ins, lg, ld, op, sl);
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), lg, ld, op, sl);
      chk_perf("perf_random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
